dht_rx_param: RTL

DHT_RX_PARAM -- requirements
Module: dht_rx_param

---
 rtl/dht_rx_param.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dht_rx_param.sv
// Single-wire DHT-style sensor receiver: issues the host start pulse, then decodes
// the sensor response and an N_BITS frame by high-time, validating the byte checksum.
module dht_rx_param #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int N_BITS        = 40,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_set,
  input  logic              inp,
  output logic              dq_oe,
  output logic [N_BITS-1:0] out,
  output logic              valid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int US_CYC     = CLK_HZ / 1_000_000;
  localparam int START_CYC  = START_LOW_US * US_CYC;
  localparam int THRESH_CYC = BIT_THRESH_US * US_CYC;
  localparam int TO_CYC     = TIMEOUT_US * US_CYC;
  localparam int MAX_A      = (START_CYC > TO_CYC) ? START_CYC : TO_CYC;
  localparam int MAX_CYC    = (MAX_A > THRESH_CYC) ? MAX_A : THRESH_CYC;
  localparam int CW         = $clog2(MAX_CYC + 1);
  localparam int BW         = $clog2(N_BITS);
  localparam int NBYTES     = N_BITS / 8;

  typedef enum logic [2:0] {
    IDLE, START, REL, RESP_L, RESP_H, BIT_L, BIT_H, CHECK
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next, cnt_inc;
  logic [BW-1:0]     bit_idx_reg, bit_idx_next;
  logic [N_BITS-1:0] shift_reg, shift_next;
  logic [N_BITS-1:0] out_reg, out_next;
  logic              valid_reg, valid_next;
  logic              err_reg, err_next;
  logic [1:0]        err_code_reg, err_code_next;

  // Two synchroniser flops plus one history flop; all edges come from the synchronised line.
  logic sync1_reg, sync2_reg, line_d_reg;
  logic rise, fall, timeout, bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      line_d_reg <= 1'b1;
    end else begin
      sync1_reg  <= inp;
      sync2_reg  <= sync1_reg;
      line_d_reg <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~line_d_reg;
  assign fall = ~sync2_reg & line_d_reg;

  // Running sum of the payload bytes (all but the lowest), reduced modulo 256.
  logic [7:0] acc [NBYTES-1];
  generate
    for (genvar gi = 0; gi < NBYTES - 1; gi++) begin : g_sum
      if (gi == NBYTES - 2) begin : g_top
        assign acc[gi] = shift_reg[8*(gi+1) +: 8];
      end else begin : g_mid
        assign acc[gi] = acc[gi+1] + shift_reg[8*(gi+1) +: 8];
      end
    end
  endgenerate

  assign cnt_inc = (cnt_reg == CW'(MAX_CYC)) ? cnt_reg : cnt_reg + 1'b1;
  assign timeout = (cnt_reg >= CW'(TO_CYC));
  // The rising-edge cycle itself is spent in BIT_L, so the high time is cnt_reg + 1.
  assign bit_val = (cnt_reg >= CW'(THRESH_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      out_reg      <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      out_reg      <= out_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_inc;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    out_next      = out_reg;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (en_set) begin
          state_next    = START;
          shift_next    = '0;
          bit_idx_next  = '0;
          err_code_next = 2'b00;
        end
      end
      START: begin
        if (cnt_reg == CW'(START_CYC - 1)) begin
          state_next = REL;
          cnt_next   = '0;
        end
      end
      REL, RESP_L, RESP_H: begin
        if ((state_reg == RESP_L) ? rise : fall) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          case (state_reg)
            REL:     state_next = RESP_L;
            RESP_L:  state_next = RESP_H;
            default: state_next = BIT_L;
          endcase
        end else if (timeout) begin
          state_next    = IDLE;
          err_next      = 1'b1;
          err_code_next = 2'b01;
        end
      end
      BIT_L: begin
        if (rise) begin
          state_next = BIT_H;
          cnt_next   = '0;
        end else if (timeout) begin
          state_next    = IDLE;
          err_next      = 1'b1;
          err_code_next = 2'b10;
        end
      end
      BIT_H: begin
        if (fall) begin
          shift_next = {shift_reg[N_BITS-2:0], bit_val};
          cnt_next   = '0;
          if (bit_idx_reg == BW'(N_BITS - 1)) begin
            state_next = CHECK;
          end else begin
            state_next   = BIT_L;
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end else if (timeout) begin
          state_next    = IDLE;
          err_next      = 1'b1;
          err_code_next = 2'b10;
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (acc[0] == shift_reg[7:0]) begin
          out_next   = shift_reg;
          valid_next = 1'b1;
        end else begin
          err_next      = 1'b1;
          err_code_next = 2'b11;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dq_oe    = (state_reg == START);
  assign busy     = (state_reg != IDLE);
  assign out      = out_reg;
  assign valid    = valid_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;

endmodule
